int_ctrl: RTL and testbench

Four-source interrupt controller sitting between external interrupt lines and the CPU's microprogram sequencer. Rising-edge detection and pending latches per source, a mask register, and a global enable driven by the CPU's STI/CLI micro-operations. A fixed-priority winner is presented to the sequencer via an `int_req`/`int_ack` handshake, then tracked as in-service until end-of-interrupt. `int_vec` supplies the 8-bit entry address that the sequencer loads into PC.

---
 rtl/int_ctrl_if.sv | 27 ++
 rtl/int_ctrl.sv | 158 +++++++++++++++
 tb/tb_int_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// Signal bundle between the interrupt controller and the CPU microprogram
// sequencer: interrupt lines, enable/mask controls and the request handshake.
interface int_ctrl_if;
  logic [3:0] irq;
  logic       sti;
  logic       cli;
  logic       ld_mask;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       eoi;
  logic       int_req;
  logic [7:0] int_vec;
  logic       ie;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] in_service;

  modport master (
    output irq, sti, cli, ld_mask, mask_in, int_ack, eoi,
    input  int_req, int_vec, ie, pending, mask, in_service
  );

  modport slave (
    input  irq, sti, cli, ld_mask, mask_in, int_ack, eoi,
    output int_req, int_vec, ie, pending, mask, in_service
  );
endinterface

// File: rtl/int_ctrl.sv
// Four-source fixed-priority interrupt controller: edge-latched pending bits,
// mask, global enable and a req/ack/eoi handshake toward the sequencer.
module int_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic     clk,
  input  logic     reset,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] irq_d_r;
  logic       armed_r;
  logic [3:0] pending_r, pending_s;
  logic [3:0] mask_r, mask_s;
  logic [3:0] in_service_r, in_service_s;
  logic       ie_r, ie_s;
  logic       int_req_r, int_req_s;
  logic [1:0] src_r, src_s;
  logic [7:0] vec_r, vec_s;
  logic [3:0] rise_s;
  logic [3:0] eligible_s;
  logic [3:0] clr_s;
  logic [1:0] win_s;
  logic       ack_s;

  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    if (v[0]) begin
      return 2'd0;
    end else if (v[1]) begin
      return 2'd1;
    end else if (v[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  function automatic logic [7:0] vec_of(input logic [1:0] s);
    return VEC_BASE + {4'b0000, s, 2'b00};
  endfunction

  // The first edge after reset only primes irq_d, so a line already held high
  // through reset is not mistaken for a fresh rising edge.
  assign rise_s     = armed_r ? (bus.irq & ~irq_d_r) : 4'b0000;
  assign eligible_s = pending_r & ~mask_r;
  assign win_s      = prio_enc(eligible_s);

  // Next-state, handshake and register-update decode
  always_comb begin
    state_s      = state_r;
    src_s        = src_r;
    vec_s        = vec_r;
    in_service_s = in_service_r;
    clr_s        = 4'b0000;
    ack_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (ie_r && (eligible_s != 4'b0000)) begin
          state_s = REQ;
          src_s   = win_s;
          vec_s   = vec_of(win_s);
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.cli) begin
          state_s = IDLE;
        end else if (bus.int_ack) begin
          state_s      = SERVICE;
          clr_s        = one_hot(src_r);
          in_service_s = one_hot(src_r);
          ack_s        = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_s      = IDLE;
          in_service_s = 4'b0000;
        end else begin
          state_s = SERVICE;
        end
      end
      default: begin
        state_s      = IDLE;
        in_service_s = 4'b0000;
      end
    endcase

    int_req_s = (state_s == REQ);
    // A new edge on the bit being acknowledged keeps it pending.
    pending_s = (pending_r & ~clr_s) | rise_s;

    if (bus.ld_mask) begin
      mask_s = bus.mask_in;
    end else begin
      mask_s = mask_r;
    end

    if (bus.cli) begin
      ie_s = 1'b0;
    end else if (ack_s) begin
      ie_s = 1'b0;
    end else if (bus.sti) begin
      ie_s = 1'b1;
    end else begin
      ie_s = ie_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      irq_d_r      <= 4'b0000;
      armed_r      <= 1'b0;
      pending_r    <= 4'b0000;
      mask_r       <= 4'b0000;
      in_service_r <= 4'b0000;
      ie_r         <= 1'b0;
      int_req_r    <= 1'b0;
      src_r        <= 2'd0;
      vec_r        <= VEC_BASE;
    end else begin
      state_r      <= state_s;
      irq_d_r      <= bus.irq;
      armed_r      <= 1'b1;
      pending_r    <= pending_s;
      mask_r       <= mask_s;
      in_service_r <= in_service_s;
      ie_r         <= ie_s;
      int_req_r    <= int_req_s;
      src_r        <= src_s;
      vec_r        <= vec_s;
    end
  end

  assign bus.int_req    = int_req_r;
  assign bus.int_vec    = vec_r;
  assign bus.ie         = ie_r;
  assign bus.pending    = pending_r;
  assign bus.mask       = mask_r;
  assign bus.in_service = in_service_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_int_ctrl;

  localparam logic [7:0] VB = 8'h20;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   chk_en;

  int_ctrl_if bus ();

  int_ctrl #(.VEC_BASE(VB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = in service.
  int         m_phase = 0;
  int         m_src = 0;
  bit         m_ie = 1'b0;
  bit         m_req = 1'b0;
  bit         m_armed = 1'b0;
  logic [3:0] m_prev = 4'b0000;
  logic [3:0] m_pend = 4'b0000;
  logic [3:0] m_mask = 4'b0000;
  logic [3:0] m_isv = 4'b0000;
  logic [7:0] m_vec = VB;
  logic [3:0] r_rise, r_elig, r_clr;
  int         r_win;
  bit         r_ack;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_src = 0; m_ie = 1'b0; m_req = 1'b0; m_armed = 1'b0;
      m_prev = 4'b0000; m_pend = 4'b0000; m_mask = 4'b0000;
      m_isv = 4'b0000; m_vec = VB;
    end else begin
      r_rise = m_armed ? (bus.irq & ~m_prev) : 4'b0000;
      r_elig = m_pend & ~m_mask;
      r_clr  = 4'b0000;
      r_ack  = 1'b0;
      r_win  = -1;
      for (int i = 3; i >= 0; i--) if (r_elig[i]) r_win = i;
      if (m_phase == 0) begin
        if (m_ie && r_win >= 0) begin
          m_src = r_win;
          m_vec = VB + 8'(4 * r_win);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (bus.cli) m_phase = 0;
        else if (bus.int_ack) begin
          r_clr[m_src] = 1'b1;
          m_isv = 4'b0000;
          m_isv[m_src] = 1'b1;
          r_ack = 1'b1;
          m_phase = 2;
        end
      end else begin
        if (bus.eoi) begin
          m_isv = 4'b0000;
          m_phase = 0;
        end
      end
      if (bus.cli || r_ack) m_ie = 1'b0;
      else if (bus.sti) m_ie = 1'b1;
      m_pend = (m_pend & ~r_clr) | r_rise;
      if (bus.ld_mask) m_mask = bus.mask_in;
      m_prev  = bus.irq;
      m_armed = 1'b1;
      m_req   = (m_phase == 1);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("int_req",    8'(bus.int_req),    8'(m_req));
      chk("int_vec",    bus.int_vec,        m_vec);
      chk("ie",         8'(bus.ie),         8'(m_ie));
      chk("pending",    8'(bus.pending),    8'(m_pend));
      chk("mask",       8'(bus.mask),       8'(m_mask));
      chk("in_service", 8'(bus.in_service), 8'(m_isv));
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    bus.irq = 4'b0000; bus.sti = 1'b0; bus.cli = 1'b0; bus.ld_mask = 1'b0;
    bus.mask_in = 4'b0000; bus.int_ack = 1'b0; bus.eoi = 1'b0;
  endtask

  initial begin
    logic [3:0] tog;
    total = 0;
    bad = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    zero_inputs();
    repeat (2) nxt();
    chk_en = 1'b1;
    reset = 1'b0;
    nxt();
    chk("rst_req", 8'(bus.int_req), 8'h00);
    chk("rst_ie", 8'(bus.ie), 8'h00);
    chk("rst_pend", 8'(bus.pending), 8'h00);
    chk("rst_mask", 8'(bus.mask), 8'h00);
    chk("rst_isv", 8'(bus.in_service), 8'h00);
    chk("rst_vec", bus.int_vec, 8'h20);

    // basic flow on source 2
    bus.sti = 1'b1; nxt();
    bus.sti = 1'b0; bus.irq = 4'b0100; nxt();
    chk("basic_pend", 8'(bus.pending), 8'h04);
    chk("basic_noreq_yet", 8'(bus.int_req), 8'h00);
    bus.irq = 4'b0000; nxt();
    chk("basic_req", 8'(bus.int_req), 8'h01);
    chk("basic_vec", bus.int_vec, 8'h28);
    bus.int_ack = 1'b1; nxt();
    chk("basic_isv", 8'(bus.in_service), 8'h04);
    chk("basic_ie_off", 8'(bus.ie), 8'h00);
    chk("basic_pend_clr", 8'(bus.pending), 8'h00);
    chk("basic_req_drop", 8'(bus.int_req), 8'h00);
    bus.int_ack = 1'b0; bus.eoi = 1'b1; nxt();
    chk("basic_eoi", 8'(bus.in_service), 8'h00);
    bus.eoi = 1'b0;

    // priority: sources 1 and 3 together
    bus.sti = 1'b1; nxt();
    bus.sti = 1'b0; bus.irq = 4'b1010; nxt();
    bus.irq = 4'b0000; nxt();
    chk("prio_first_vec", bus.int_vec, 8'h24);
    chk("prio_first_req", 8'(bus.int_req), 8'h01);
    bus.int_ack = 1'b1; nxt();
    bus.int_ack = 1'b0; bus.sti = 1'b1; bus.eoi = 1'b1; nxt();
    bus.sti = 1'b0; bus.eoi = 1'b0; nxt();
    chk("prio_second_req", 8'(bus.int_req), 8'h01);
    chk("prio_second_vec", bus.int_vec, 8'h2c);
    chk("model_vec_pin", m_vec, 8'h2c);
    bus.int_ack = 1'b1; nxt();
    bus.int_ack = 1'b0; bus.eoi = 1'b1; bus.sti = 1'b1;
    bus.ld_mask = 1'b1; bus.mask_in = 4'b0001; nxt();

    // mask blocks source 0 until cleared
    bus.eoi = 1'b0; bus.sti = 1'b0; bus.ld_mask = 1'b0; bus.irq = 4'b0001; nxt();
    chk("mask_pend", 8'(bus.pending), 8'h01);
    bus.irq = 4'b0000; nxt();
    chk("mask_blocked", 8'(bus.int_req), 8'h00);
    nxt();
    chk("mask_blocked2", 8'(bus.int_req), 8'h00);
    bus.ld_mask = 1'b1; bus.mask_in = 4'b0000; nxt();
    bus.ld_mask = 1'b0;
    chk("unmask_wait", 8'(bus.int_req), 8'h00);
    nxt();
    chk("unmask_req", 8'(bus.int_req), 8'h01);
    chk("unmask_vec", bus.int_vec, 8'h20);

    // withdrawal by cli
    bus.cli = 1'b1; nxt();
    bus.cli = 1'b0;
    chk("wd_req", 8'(bus.int_req), 8'h00);
    chk("wd_pend", 8'(bus.pending), 8'h01);
    chk("wd_ie", 8'(bus.ie), 8'h00);
    nxt(); nxt();
    chk("wd_no_ie_no_req", 8'(bus.int_req), 8'h00);
    bus.sti = 1'b1; nxt();
    bus.sti = 1'b0; nxt();
    chk("wd_rereq", 8'(bus.int_req), 8'h01);

    // new edge during ack keeps pending; ack in service ignored
    bus.int_ack = 1'b1; bus.irq = 4'b0001; nxt();
    chk("coll_b_pend", 8'(bus.pending), 8'h01);
    chk("coll_b_isv", 8'(bus.in_service), 8'h01);
    bus.irq = 4'b0000; nxt();
    chk("coll_c_ack_isv", 8'(bus.in_service), 8'h01);
    chk("coll_c_ack_req", 8'(bus.int_req), 8'h00);
    bus.int_ack = 1'b0; bus.eoi = 1'b1; nxt();
    chk("coll_c_eoi", 8'(bus.in_service), 8'h00);
    nxt();
    chk("coll_c_idle_eoi_isv", 8'(bus.in_service), 8'h00);
    chk("coll_c_idle_eoi_pend", 8'(bus.pending), 8'h01);
    chk("coll_c_idle_eoi_req", 8'(bus.int_req), 8'h00);
    bus.eoi = 1'b0;
    bus.sti = 1'b1; bus.cli = 1'b1; nxt();
    bus.sti = 1'b0; bus.cli = 1'b0;
    chk("coll_a_ie", 8'(bus.ie), 8'h00);

    // asynchronous reset in service; held-high line must not retrigger
    bus.sti = 1'b1; nxt();
    bus.sti = 1'b0; nxt();
    chk("rs_req", 8'(bus.int_req), 8'h01);
    bus.int_ack = 1'b1; bus.irq = 4'b0100; nxt();
    bus.int_ack = 1'b0;
    chk("rs_isv_pre", 8'(bus.in_service), 8'h01);
    chk("rs_pend_pre", 8'(bus.pending), 8'h04);
    #2 reset = 1'b1;
    #1;
    chk("rs_isv", 8'(bus.in_service), 8'h00);
    chk("rs_req0", 8'(bus.int_req), 8'h00);
    chk("rs_ie", 8'(bus.ie), 8'h00);
    chk("rs_pend", 8'(bus.pending), 8'h00);
    chk("rs_vec", bus.int_vec, 8'h20);
    #1 reset = 1'b0;
    nxt(); nxt();
    chk("rs_held_no_trig", 8'(bus.pending), 8'h00);
    bus.irq = 4'b0000; nxt();
    bus.irq = 4'b0100; nxt();
    chk("rs_retrig", 8'(bus.pending), 8'h04);
    chk("model_pend_pin", 8'(m_pend), 8'h04);

    // randomized traffic checked by the compare process
    for (int c = 0; c < 4000; c++) begin
      nxt();
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      tog = 4'($urandom());
      if ($urandom_range(0, 2) != 0) tog = tog & 4'($urandom());
      if ($urandom_range(0, 1) != 0) tog = 4'b0000;
      bus.irq     = bus.irq ^ tog;
      bus.sti     = ($urandom_range(0, 5) == 0);
      bus.cli     = ($urandom_range(0, 15) == 0);
      bus.ld_mask = ($urandom_range(0, 15) == 0);
      bus.mask_in = 4'($urandom()) & 4'($urandom());
      bus.int_ack = ($urandom_range(0, 2) == 0);
      bus.eoi     = ($urandom_range(0, 3) == 0);
    end
    nxt();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
